// File: rtl/control_cronometro.sv
// Stopwatch sequencer: filters PS/2 set-2 break sequences, runs the
// PARADO/CORRIENDO/PAUSADO control FSM and owns the BCD hh:mm:ss counter.
module control_cronometro #(
    parameter logic [7:0] TECLA_INICIO = 8'h75,
    parameter logic [7:0] TECLA_PAUSA  = 8'h72,
    parameter logic [7:0] TECLA_BORRAR = 8'h66,
    parameter logic [7:0] HORA_MAX     = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tecla,
    input  logic       tecla_valida,
    input  logic       tick_1hz,
    output logic [1:0] estado,
    output logic       corriendo,
    output logic [7:0] seg_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hora_bcd,
    output logic       desborde
);

    typedef enum logic [1:0] {
        PARADO    = 2'b00,
        CORRIENDO = 2'b01,
        PAUSADO   = 2'b10
    } estado_t;

    estado_t    estado_q, estado_d;
    logic       corriendo_q, corriendo_d;
    logic [7:0] seg_q, seg_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hora_q, hora_d;
    logic       desborde_q, desborde_d;
    logic       flag_break_q, flag_break_d;
    logic       es_comando_s;

    // Two-digit BCD increment; callers handle the field wrap themselves.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Break filter, counter advance and FSM next state.
    always_comb begin
        estado_d     = estado_q;
        seg_d        = seg_q;
        min_d        = min_q;
        hora_d       = hora_q;
        desborde_d   = 1'b0;
        flag_break_d = flag_break_q;
        es_comando_s = 1'b0;

        if (tecla_valida) begin
            if (Tecla == 8'hF0) begin
                flag_break_d = 1'b1;
            end else if (Tecla == 8'hE0) begin
                flag_break_d = flag_break_q;
            end else if (flag_break_q) begin
                flag_break_d = 1'b0;
            end else begin
                es_comando_s = 1'b1;
            end
        end else begin
            es_comando_s = 1'b0;
        end

        // Counting uses the pre-edge state, so a tick arriving with INICIO is lost.
        if (tick_1hz && (estado_q == CORRIENDO)) begin
            if (seg_q == 8'h59) begin
                seg_d = 8'h00;
                if (min_q == 8'h59) begin
                    min_d = 8'h00;
                    if (hora_q == HORA_MAX) begin
                        hora_d     = 8'h00;
                        desborde_d = 1'b1;
                    end else begin
                        hora_d = bcd_inc(hora_q);
                    end
                end else begin
                    min_d = bcd_inc(min_q);
                end
            end else begin
                seg_d = bcd_inc(seg_q);
            end
        end else begin
            seg_d = seg_q;
        end

        case (estado_q)
            PARADO: begin
                if (es_comando_s && (Tecla == TECLA_INICIO)) begin
                    estado_d = CORRIENDO;
                end else begin
                    estado_d = PARADO;
                end
            end
            CORRIENDO: begin
                if (es_comando_s && (Tecla == TECLA_PAUSA)) begin
                    estado_d = PAUSADO;
                end else begin
                    estado_d = CORRIENDO;
                end
            end
            PAUSADO: begin
                if (es_comando_s && (Tecla == TECLA_INICIO)) begin
                    estado_d = CORRIENDO;
                end else if (es_comando_s && (Tecla == TECLA_BORRAR)) begin
                    estado_d = PARADO;
                    seg_d    = 8'h00;
                    min_d    = 8'h00;
                    hora_d   = 8'h00;
                end else begin
                    estado_d = PAUSADO;
                end
            end
            default: begin
                estado_d = PARADO;
            end
        endcase

        corriendo_d = (estado_d == CORRIENDO);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= PARADO;
            corriendo_q  <= 1'b0;
            seg_q        <= 8'h00;
            min_q        <= 8'h00;
            hora_q       <= 8'h00;
            desborde_q   <= 1'b0;
            flag_break_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            corriendo_q  <= corriendo_d;
            seg_q        <= seg_d;
            min_q        <= min_d;
            hora_q       <= hora_d;
            desborde_q   <= desborde_d;
            flag_break_q <= flag_break_d;
        end
    end

    assign estado    = estado_q;
    assign corriendo = corriendo_q;
    assign seg_bcd   = seg_q;
    assign min_bcd   = min_q;
    assign hora_bcd  = hora_q;
    assign desborde  = desborde_q;

endmodule

// File: tb/tb_control_cronometro.sv
// Directed self-checking bench for the stopwatch sequencer.
module tb_control_cronometro;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] Tecla = 8'h00;
    logic       tecla_valida = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [1:0] estado;
    logic       corriendo;
    logic [7:0] seg_bcd, min_bcd, hora_bcd;
    logic       desborde;

    int total = 0;
    int bad = 0;
    int desb_cnt = 0;

    control_cronometro dut (
        .clk(clk), .reset(reset), .Tecla(Tecla), .tecla_valida(tecla_valida),
        .tick_1hz(tick_1hz), .estado(estado), .corriendo(corriendo),
        .seg_bcd(seg_bcd), .min_bcd(min_bcd), .hora_bcd(hora_bcd),
        .desborde(desborde)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (desborde === 1'b1) desb_cnt++;
    end

    task automatic key(input logic [7:0] b);
        @(negedge clk);
        Tecla = b; tecla_valida = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0;
    endtask

    task automatic ticks(input int n);
        @(negedge clk);
        tick_1hz = 1'b1;
        repeat (n) @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic chk_state(input string nm, input logic [1:0] exp_st);
        total++;
        if (estado !== exp_st || corriendo !== (exp_st == 2'b01)) begin
            bad++;
            $display("FAIL %s: estado=%b corriendo=%b expected estado=%b", nm, estado, corriendo, exp_st);
        end
    endtask

    task automatic chk_time(input string nm, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        total++;
        if (hora_bcd !== h || min_bcd !== m || seg_bcd !== s) begin
            bad++;
            $display("FAIL %s: got %h:%h:%h expected %h:%h:%h", nm, hora_bcd, min_bcd, seg_bcd, h, m, s);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_state("reset_state", 2'b00);
        chk_time("reset_time", 8'h00, 8'h00, 8'h00);
        total++;
        if (desborde !== 1'b0) begin
            bad++;
            $display("FAIL reset_desborde: got %b expected 0", desborde);
        end
        ticks(3);
        @(negedge clk);
        chk_state("idle_ticks_state", 2'b00);
        chk_time("idle_ticks_time", 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_run_pause;
        key(8'h75);
        chk_state("start", 2'b01);
        ticks(5);
        key(8'h72);
        chk_state("pause", 2'b10);
        ticks(3);
        chk_time("paused_hold", 8'h00, 8'h00, 8'h05);
        key(8'h75);
        chk_state("resume", 2'b01);
        ticks(1);
        chk_time("resume_count", 8'h00, 8'h00, 8'h06);
        key(8'h66);
        chk_state("borrar_running_ignored", 2'b01);
        key(8'h72);
        key(8'h72);
        chk_state("pausa_while_paused", 2'b10);
        key(8'h66);
        chk_state("borrar_paused", 2'b00);
        chk_time("borrar_paused_time", 8'h00, 8'h00, 8'h00);
        key(8'h72);
        chk_state("pausa_while_stopped", 2'b00);
    endtask

    task automatic test_break_filter;
        key(8'hE0); key(8'h75);
        chk_state("ext_press", 2'b01);
        key(8'hE0); key(8'hF0); key(8'h75);
        chk_state("ext_release", 2'b01);
        key(8'h72);
        chk_state("pause_after_release", 2'b10);
        key(8'hF0); key(8'h75);
        chk_state("break_discards_inicio", 2'b10);
        key(8'hF0); key(8'hE0); key(8'h66);
        chk_state("break_survives_e0", 2'b10);
        key(8'h11);
        chk_state("unknown_noop", 2'b10);
        key(8'h66);
        chk_state("clear_after_filter", 2'b00);
    endtask

    task automatic test_wrap;
        key(8'h75);
        ticks(60);
        chk_time("sixty_ticks", 8'h00, 8'h01, 8'h00);
        ticks(36000 - 60);
        chk_time("ten_hours", 8'h10, 8'h00, 8'h00);
        ticks(86399 - 36000);
        chk_time("max_time", 8'h23, 8'h59, 8'h59);
        total++;
        if (desb_cnt !== 0) begin
            bad++;
            $display("FAIL early_desborde: count=%0d expected 0", desb_cnt);
        end
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        chk_time("wrap_time", 8'h00, 8'h00, 8'h00);
        total++;
        if (desborde !== 1'b1) begin
            bad++;
            $display("FAIL wrap_desborde: got %b expected 1", desborde);
        end
        @(negedge clk);
        total++;
        if (desborde !== 1'b0 || desb_cnt !== 1) begin
            bad++;
            $display("FAIL desborde_pulse: got %b count=%0d expected 0 count=1", desborde, desb_cnt);
        end
        chk_state("wrap_state", 2'b01);
    endtask

    task automatic test_clear;
        ticks(7);
        key(8'h72);
        chk_time("paused_seven", 8'h00, 8'h00, 8'h07);
        @(negedge clk);
        Tecla = 8'h66; tecla_valida = 1'b1; tick_1hz = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0; tick_1hz = 1'b0;
        chk_state("borrar_tick_state", 2'b00);
        chk_time("borrar_tick_time", 8'h00, 8'h00, 8'h00);
        key(8'h75);
        ticks(2);
        key(8'h66);
        ticks(1);
        chk_state("borrar_run_state", 2'b01);
        chk_time("borrar_run_time", 8'h00, 8'h00, 8'h03);
    endtask

    task automatic test_back_to_back;
        ticks(6);
        chk_time("at_nine", 8'h00, 8'h00, 8'h09);
        @(negedge clk);
        Tecla = 8'h72; tecla_valida = 1'b1; tick_1hz = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0; tick_1hz = 1'b0;
        chk_state("pausa_tick_state", 2'b10);
        chk_time("pausa_tick_time", 8'h00, 8'h00, 8'h10);
        @(negedge clk);
        Tecla = 8'h75; tecla_valida = 1'b1; tick_1hz = 1'b1;
        @(negedge clk);
        tecla_valida = 1'b0; tick_1hz = 1'b0;
        chk_state("inicio_tick_state", 2'b01);
        chk_time("inicio_tick_time", 8'h00, 8'h00, 8'h10);
        ticks(4);
        key(8'hF0);
        @(negedge clk);
        reset = 1'b1; tick_1hz = 1'b1;
        @(negedge clk);
        reset = 1'b0; tick_1hz = 1'b0;
        chk_state("midrun_reset_state", 2'b00);
        chk_time("midrun_reset_time", 8'h00, 8'h00, 8'h00);
        key(8'h75);
        chk_state("break_cleared_by_reset", 2'b01);
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_break_filter();
        test_wrap();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
